// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: hazard/redirect controls, instruction-memory port and IF/ID output.
// The master modport is the fetch unit. The slave modport is its environment (memory, decode, hazard unit).
interface if_fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            stall;
    logic            redirect_en;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc4;
    logic            out_valid;

    modport master (
        input  stall, redirect_en, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, out_inst, out_pc4, out_valid
    );

    modport slave (
        output stall, redirect_en, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, out_inst, out_pc4, out_valid
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end.
// Owns the PC and issues one outstanding imem request at a time.
// Holds the fetched word until decode consumes it.
// Redirects discard any wrong-path fetch that is still in flight.
// Optional feature: define FETCH_CNT_EN to add the fetch_count output, which counts consumed instructions.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    if_fetch_unit_if.master      bus
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0]          fetch_count
`endif
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] out_inst_q, out_inst_d;
    logic [XLEN-1:0] out_pc4_q, out_pc4_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] pc_plus4;
    logic            consume;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign consume  = out_valid_q & ~bus.stall;

    // Request strobe is a pure decode of the state; the address always tracks the PC.
    assign bus.imem_req  = (state_q == S_REQ);
    assign bus.imem_addr = pc_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_pc4   = out_pc4_q;
    assign bus.out_valid = out_valid_q;

    // State, PC and IF/ID output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            out_inst_q  <= '0;
            out_pc4_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            out_inst_q  <= out_inst_d;
            out_pc4_q   <= out_pc4_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic. A redirect takes priority over stall and ack.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        out_inst_d  = out_inst_q;
        out_pc4_d   = out_pc4_q;
        out_valid_d = out_valid_q;

        if (consume) begin
            out_valid_d = 1'b0;
        end

        if (bus.redirect_en) begin
            pc_d        = bus.redirect_pc & ~XLEN'(3);
            out_valid_d = 1'b0;
            unique case (state_q)
                // A request is already in flight; its data must be thrown away.
                S_REQ: begin
                    drop_d  = 1'b1;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.imem_ack) begin
                        // The in-flight data is arriving now, so discard it here.
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                default: begin
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                end
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ:  state_d = S_WAIT;
                S_WAIT: begin
                    if (bus.imem_ack) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            out_inst_d  = bus.imem_rdata;
                            out_pc4_d   = pc_plus4;
                            out_valid_d = 1'b1;
                            pc_d        = pc_plus4;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef FETCH_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    // Count instructions accepted by decode. A redirect in the same cycle invalidates the held word.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (consume && !bus.redirect_en) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // Consumed-instruction counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end that produces the instruction/PC+4 pair feeding the IF/ID pipeline register.
- Owns the program counter and issues single-outstanding requests to instruction memory.
- Holds each fetched word until the decode side accepts it.
- Accepts stall from the hazard unit and redirect (branch/jump) from later stages, discarding wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
stall  input  1  1 = decode side not accepting this cycle.
redirect_en  input  1  single-cycle pulse: fetch must restart at redirect_pc.
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0).
imem_req  output  1  memory request strobe, one cycle per request.
imem_addr  output  32  word-aligned fetch address (= pc).
imem_ack  input  1  read data valid this cycle.
imem_rdata  input  32  instruction word, valid when imem_ack=1.
out_inst  output  32  fetched instruction to IF/ID.
out_pc4  output  32  address of out_inst + 4, to IF/ID.
out_valid  output  1  out_inst/out_pc4 hold a valid, unconsumed instruction.

Behaviour:
- Clock and reset: single clock clk; reset asynchronous, active-low. All state updates on the rising edge of clk.
- Reset values: state=IDLE, pc=RESET_PC, drop=0, imem_req=0, imem_addr=RESET_PC, out_inst=32'h0000_0000 (NOP), out_pc4=0, out_valid=0.
- imem_req=1 only in state REQ (decoded from state). imem_addr=pc at all times.
- Consume: a cycle with out_valid=1 and stall=0. At that edge out_valid clears unless reloaded the same edge.
- State machine:
  - IDLE: unconditionally -> REQ next cycle. Request at RESET_PC is issued on the 2nd cycle after reset release.
  - REQ: imem_req=1 for exactly one cycle -> WAIT.
  - WAIT:
    - imem_ack=1, drop=0, no redirect: out_inst<=imem_rdata, out_pc4<=pc+4, out_valid<=1, pc<=pc+4 -> HOLD.
    - imem_ack=1, drop=1: discard data, drop<=0 -> REQ.
  - HOLD: when a consume occurs -> REQ. While stall=1, stay in HOLD with outputs frozen.
- Redirect (highest priority, overrides stall and ack):
  - pc<=redirect_pc & ~3.
  - out_valid<=0.
  - From REQ or WAIT (request outstanding): drop<=1, go or stay WAIT. If imem_ack is high in the same cycle, discard that data, drop stays 0 -> REQ.
  - From HOLD or IDLE: -> REQ.
- Arithmetic: pc+4 is 32-bit modulo; pc=32'hFFFF_FFFC yields out_pc4=0 and next pc=0.
- At most one outstanding request at any time; imem_ack outside WAIT is ignored.
- imem_ack must not be assumed to arrive within a fixed latency; WAIT waits indefinitely.
- Reset mid-operation forces reset values immediately, asynchronously. Instruction memory shares the same reset, so no stale ack is expected.
- Throughput: one instruction per 3 cycles with 1-cycle memory latency and no stall.

Optional Feature:
- Macro FETCH_CNT_EN.
- Defined: adds output fetch_count[31:0], reset 0. Increments by 1 on every consume; wraps at 2^32. Not incremented for dropped or redirected-away instructions.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, 1-cycle ack memory returning 32'h2008_0005 at addr 0 -> imem_req high with imem_addr=0 two cycles after release. Then out_inst=32'h2008_0005, out_pc4=4, out_valid=1. Next request at imem_addr=4.
- stall=1 for 5 cycles while out_valid=1 -> out_inst/out_pc4 unchanged and no imem_req. After stall drops, out_valid clears and imem_req fires at the next pc.
- redirect_en with redirect_pc=32'h0000_0103 during WAIT, ack 2 cycles later with data 32'hDEAD_BEEF -> data discarded, out_valid stays 0. Next imem_addr=32'h0000_0100.
- redirect_en coincident with imem_ack in WAIT -> ack data discarded, next cycle REQ at redirect_pc, drop=0.
- pc forced via redirect to 32'hFFFF_FFFC, ack returned -> out_pc4=0 and next imem_addr=0.
- Assert reset (0) while in WAIT -> outputs immediately at reset values. With FETCH_CNT_EN, after 3 consumes fetch_count=3 and it returns to 0 on reset.
